// File: rtl/sfm_op_pipe.sv
// sfm_op_pipe: elastic valid/ready register stages placed before/after/around a combinational
// softmax datapath operator. Define SFM_OP_PIPE_PERF_CNT_EN to add the stall_cnt_o counter.

package sfm_pkg;
  typedef enum logic [1:0] {
    BEFORE = 2'd0,
    AFTER  = 2'd1,
    AROUND = 2'd2
  } regs_config_t;
endpackage

module sfm_op_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         up_valid_i,
  output logic         up_ready_o,
  input  logic [W-1:0] up_data_i,
  output logic         dn_valid_o,
  input  logic         dn_ready_i,
  output logic [W-1:0] dn_data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign up_ready_o = ~valid_q | dn_ready_i;

  // Clear drops valid but keeps data; data only moves on a handshake.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (up_ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
endmodule

module sfm_op_pipe #(
  parameter int unsigned           DATA_W     = 32,
  parameter int unsigned           RES_W      = 16,
  parameter int unsigned           TAG_W      = 4,
  parameter int unsigned           NUM_REGS   = 2,
  parameter sfm_pkg::regs_config_t REG_CONFIG = sfm_pkg::AROUND
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic [DATA_W-1:0] dp_op_o,
  input  logic [RES_W-1:0]  dp_res_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RES_W-1:0]  out_res_o,
  output logic [TAG_W-1:0]  out_tag_o
`ifdef SFM_OP_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);
  localparam int unsigned NB = (REG_CONFIG == sfm_pkg::BEFORE) ? NUM_REGS :
                               (REG_CONFIG == sfm_pkg::AFTER)  ? 32'd0 : (NUM_REGS / 32'd2);
  localparam int unsigned NA = NUM_REGS - NB;
  localparam int unsigned BW = DATA_W + TAG_W;
  localparam int unsigned AW = RES_W + TAG_W;

  // Index 0 of each chain is its input side; index N is its output side.
  logic          b_vld_s [NB+1];
  logic          b_rdy_s [NB+1];
  logic [BW-1:0] b_dat_s [NB+1];
  logic          a_vld_s [NA+1];
  logic          a_rdy_s [NA+1];
  logic [AW-1:0] a_dat_s [NA+1];

  assign b_vld_s[0]  = in_valid_i;
  assign b_dat_s[0]  = {in_data_i, in_tag_i};
  assign dp_op_o     = b_dat_s[NB][BW-1:TAG_W];
  assign a_vld_s[0]  = b_vld_s[NB];
  assign a_dat_s[0]  = {dp_res_i, b_dat_s[NB][TAG_W-1:0]};
  assign b_rdy_s[NB] = a_rdy_s[0];
  assign a_rdy_s[NA] = out_ready_i;

  for (genvar i = 0; i < NB; i++) begin : g_before
    sfm_op_stage #(.W(BW)) u_stage (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .up_valid_i (b_vld_s[i]),
      .up_ready_o (b_rdy_s[i]),
      .up_data_i  (b_dat_s[i]),
      .dn_valid_o (b_vld_s[i+1]),
      .dn_ready_i (b_rdy_s[i+1]),
      .dn_data_o  (b_dat_s[i+1])
    );
  end

  for (genvar i = 0; i < NA; i++) begin : g_after
    sfm_op_stage #(.W(AW)) u_stage (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .up_valid_i (a_vld_s[i]),
      .up_ready_o (a_rdy_s[i]),
      .up_data_i  (a_dat_s[i]),
      .dn_valid_o (a_vld_s[i+1]),
      .dn_ready_i (a_rdy_s[i+1]),
      .dn_data_o  (a_dat_s[i+1])
    );
  end

  assign out_valid_o = a_vld_s[NA];
  assign out_tag_o   = a_dat_s[NA][TAG_W-1:0];

  if (NUM_REGS != 32'd0) begin : g_regs
    // The clear cycle always accepts (and discards) the input beat.
    assign in_ready_o = clear_i | b_rdy_s[0];
  end else begin : g_comb
    assign in_ready_o = b_rdy_s[0];
  end

  if ((NA == 32'd0) && (NUM_REGS != 32'd0)) begin : g_res_gated
    // Result comes straight from the unreset datapath, so force it low in reset.
    assign out_res_o = rst_ni ? a_dat_s[NA][AW-1:TAG_W] : '0;
  end else begin : g_res_direct
    assign out_res_o = a_dat_s[NA][AW-1:TAG_W];
  end

`ifdef SFM_OP_PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the output is offered but not taken.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear_i) begin
      stall_cnt_d = 32'd0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_sfm_op_pipe.sv
// Directed self-checking bench for sfm_op_pipe: six instances cover the placement variants,
// NUM_REGS 0/2/3/4, reset, streaming, backpressure, flush and the combinational case.

module tb_sfm_op_pipe;
  import sfm_pkg::*;

  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear;
  logic [N-1:0]  in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_data;
  logic [3:0]    in_tag;
  logic [31:0]   dp_op   [N];
  logic [15:0]   dp_res  [N];
  logic [15:0]   out_res [N];
  logic [3:0]    out_tag [N];
`ifdef SFM_OP_PIPE_PERF_CNT_EN
  logic [31:0]   stall_cnt [N];
`endif
  int checks = 0;
  int errors = 0;

  function automatic int nr_of(int g);
    case (g)
      0:       return 2;
      1, 2, 3: return 3;
      4:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic regs_config_t cf_of(int g);
    case (g)
      1:       return BEFORE;
      2:       return AFTER;
      default: return AROUND;
    endcase
  endfunction

  function automatic logic [31:0] data_of(int k);
    logic [15:0] hi, lo;
    hi = 16'(k * 257 + 61440);
    lo = 16'(k * 13 + 3840);
    return {hi, lo};
  endfunction

  function automatic logic [15:0] sum16(logic [31:0] d);
    return d[31:16] + d[15:0];
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign dp_res[g] = dp_op[g][31:16] + dp_op[g][15:0];
    sfm_op_pipe #(
      .DATA_W(32), .RES_W(16), .TAG_W(4),
      .NUM_REGS(nr_of(g)), .REG_CONFIG(cf_of(g))
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .in_data_i   (in_data),
      .in_tag_i    (in_tag),
      .dp_op_o     (dp_op[g]),
      .dp_res_i    (dp_res[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .out_res_o   (out_res[g]),
      .out_tag_o   (out_tag[g])
`ifdef SFM_OP_PIPE_PERF_CNT_EN
      ,
      .stall_cnt_o (stall_cnt[g])
`endif
    );
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (out_valid[g] !== 1'b0 || out_res[g] !== 16'h0000 || out_tag[g] !== 4'h0 || in_ready[g] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b res=%h tag=%h rdy=%b, expected 0 0 0 1",
                 g, out_valid[g], out_res[g], out_tag[g], in_ready[g]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready[4] = 1'b0;
    in_valid[4]  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = data_of(k);
      in_tag  = 4'(k);
      next_cycle();
    end
    #1;
    checks++;
    if (out_valid[4] !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: out_valid=%b expected 1", out_valid[4]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[4] !== 1'b0 || out_res[4] !== 16'h0000 || out_tag[4] !== 4'h0 || in_ready[4] !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: valid=%b res=%h tag=%h rdy=%b, expected 0 0 0 1",
               out_valid[4], out_res[4], out_tag[4], in_ready[4]);
    end
    in_valid  = '0;
    out_ready = '1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_around2();
    in_data     = 32'h0003_0005;
    in_tag      = 4'h1;
    in_valid[0] = 1'b1;
    next_cycle();
    in_valid[0] = 1'b0;
    in_data     = 32'hDEAD_BEEF;
    in_tag      = 4'hF;
    #2;
    checks++;
    if (dp_op[0] !== 32'h0003_0005 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL around2_cycle1: dp_op=%h valid=%b, expected 00030005 0", dp_op[0], out_valid[0]);
    end
    next_cycle();
    #2;
    checks++;
    if (out_valid[0] !== 1'b1 || out_res[0] !== 16'h0008 || out_tag[0] !== 4'h1) begin
      errors++;
      $display("FAIL around2_result: valid=%b res=%h tag=%h, expected 1 0008 1",
               out_valid[0], out_res[0], out_tag[0]);
    end
    next_cycle();
    #2;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL around2_single: valid=%b expected 0", out_valid[0]);
    end
    next_cycle();
  endtask

  task automatic test_stream(input int g);
    int sent, rcv, c, first_c, last_c;
    sent = 0; rcv = 0; c = 0; first_c = -1; last_c = -1;
    out_ready[g] = 1'b1;
    in_valid[g]  = 1'b1;
    in_data      = data_of(0);
    in_tag       = 4'h0;
    while (rcv < 100 && c < 300) begin
      #2;
      if (out_valid[g]) begin
        checks++;
        if (out_res[g] !== sum16(data_of(rcv)) || out_tag[g] !== 4'(rcv)) begin
          errors++;
          $display("FAIL stream_dut%0d item%0d: res=%h tag=%h, expected %h %h",
                   g, rcv, out_res[g], out_tag[g], sum16(data_of(rcv)), 4'(rcv));
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        rcv++;
      end
      if (in_valid[g] && in_ready[g]) sent++;
      next_cycle();
      c++;
      if (sent < 100) begin
        in_valid[g] = 1'b1;
        in_data     = data_of(sent);
        in_tag      = 4'(sent);
      end else begin
        in_valid[g] = 1'b0;
      end
    end
    in_valid[g] = 1'b0;
    checks++;
    if (rcv != 100 || first_c != 3 || last_c != 102) begin
      errors++;
      $display("FAIL stream_timing_dut%0d: count=%0d first=%0d last=%0d, expected 100 3 102",
               g, rcv, first_c, last_c);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    int sent, rcv;
    logic [15:0] held;
    sent = 0; rcv = 0; held = 16'h0000;
    out_ready[4] = 1'b0;
    in_valid[4]  = 1'b1;
    in_data      = data_of(0);
    in_tag       = 4'h0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (c == 4) begin
        held = out_res[4];
        checks++;
        if (out_valid[4] !== 1'b1 || held !== sum16(data_of(0))) begin
          errors++;
          $display("FAIL bp_head: valid=%b res=%h, expected 1 %h", out_valid[4], held, sum16(data_of(0)));
        end
      end
      if (c == 9) begin
        checks++;
        if (in_ready[4] !== 1'b0 || out_valid[4] !== 1'b1 || out_res[4] !== held || out_tag[4] !== 4'h0) begin
          errors++;
          $display("FAIL bp_hold: rdy=%b valid=%b res=%h tag=%h, expected 0 1 %h 0",
                   in_ready[4], out_valid[4], out_res[4], out_tag[4], held);
        end
      end
      if (in_valid[4] && in_ready[4]) sent++;
      next_cycle();
      in_data = data_of(sent);
      in_tag  = 4'(sent);
    end
    checks++;
    if (sent != 4) begin
      errors++;
      $display("FAIL bp_accepts: got %0d expected 4", sent);
    end
    out_ready[4] = 1'b1;
    in_valid[4]  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (out_valid[4]) begin
        checks++;
        if (c != rcv || out_res[4] !== sum16(data_of(rcv)) || out_tag[4] !== 4'(rcv)) begin
          errors++;
          $display("FAIL bp_drain item%0d: cycle=%0d res=%h tag=%h, expected cycle %0d %h %h",
                   rcv, c, out_res[4], out_tag[4], rcv, sum16(data_of(rcv)), 4'(rcv));
        end
        rcv++;
      end
      next_cycle();
    end
    checks++;
    if (rcv != 4) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d expected 4", rcv);
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    out_ready[3] = 1'b0;
    in_valid[3]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = data_of(k + 50);
      in_tag  = 4'(k + 5);
      next_cycle();
    end
    clear   = 1'b1;
    in_data = data_of(99);
    in_tag  = 4'hA;
    #2;
    checks++;
    if (in_ready[3] !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b expected 1", in_ready[3]);
    end
    next_cycle();
    clear       = 1'b0;
    in_valid[3] = 1'b0;
    #2;
    checks++;
    if (out_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: out_valid=%b expected 0", out_valid[3]);
    end
`ifdef SFM_OP_PIPE_PERF_CNT_EN
    checks++;
    if (stall_cnt[3] !== 32'd0) begin
      errors++;
      $display("FAIL flush_stall_cnt: got %0d expected 0", stall_cnt[3]);
    end
`endif
    out_ready[3] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid[3]) seen++;
      next_cycle();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_ghost: %0d outputs seen, expected 0", seen);
    end
    in_data     = data_of(7);
    in_tag      = 4'h7;
    in_valid[3] = 1'b1;
    next_cycle();
    in_valid[3] = 1'b0;
    next_cycle();
    next_cycle();
    #2;
    checks++;
    if (out_valid[3] !== 1'b1 || out_res[3] !== sum16(data_of(7)) || out_tag[3] !== 4'h7) begin
      errors++;
      $display("FAIL flush_after: valid=%b res=%h tag=%h, expected 1 %h 7",
               out_valid[3], out_res[3], out_tag[3], sum16(data_of(7)));
    end
    next_cycle();
  endtask

  task automatic test_comb();
    logic [31:0] stall_exp;
    stall_exp = 32'd0;
    for (int c = 0; c < 24; c++) begin
      in_valid[5]  = (c == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      out_ready[5] = (c == 0) ? 1'b0 : 1'($urandom_range(1, 0));
      in_data      = $urandom();
      in_tag       = 4'($urandom_range(15, 0));
      #1;
      checks++;
      if (in_ready[5] !== out_ready[5] || out_valid[5] !== in_valid[5] ||
          out_res[5] !== sum16(in_data) || out_tag[5] !== in_tag) begin
        errors++;
        $display("FAIL comb_path c%0d: rdy=%b valid=%b res=%h tag=%h, expected %b %b %h %h",
                 c, in_ready[5], out_valid[5], out_res[5], out_tag[5],
                 out_ready[5], in_valid[5], sum16(in_data), in_tag);
      end
      if (in_valid[5] && !out_ready[5]) stall_exp++;
      next_cycle();
    end
    in_valid[5]  = 1'b0;
    out_ready[5] = 1'b1;
`ifdef SFM_OP_PIPE_PERF_CNT_EN
    #1;
    checks++;
    if (stall_cnt[5] !== stall_exp) begin
      errors++;
      $display("FAIL comb_stall_cnt: got %0d expected %0d", stall_cnt[5], stall_exp);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    in_data   = 32'h0;
    in_tag    = 4'h0;
    test_reset();
    test_around2();
    test_stream(1);
    test_stream(2);
    test_stream(3);
    test_backpressure();
    test_flush();
    test_comb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfm_op_pipe.md
Name: sfm_op_pipe

Overview:
- Elastic valid/ready pipeline wrapper that places NUM_REGS register stages around a combinational softmax datapath operator (adder, multiplier, min/max unit).
- Placement follows the package configuration type regs_config_t: BEFORE, AFTER or AROUND. The block is the consumer that gives those encodings their hardware meaning.
- Sits between stream producers and sfm datapath units. Per-transaction tag travels alongside.

Parameters:
- DATA_W, 32, width of operand bundle sent to datapath
- RES_W, 16, width of datapath result
- TAG_W, 4, sideband tag carried with each transaction
- NUM_REGS, 2, total register stages (0..8)
- REG_CONFIG, sfm_pkg::AROUND, register placement (regs_config_t)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of all stages
- in_valid_i  in  1  upstream valid
- in_ready_o  out  1  upstream ready
- in_data_i  in  DATA_W  operand bundle
- in_tag_i  in  TAG_W  tag
- dp_op_o  out  DATA_W  operands presented to combinational datapath
- dp_res_i  in  RES_W  combinational datapath result for dp_op_o
- out_valid_o  out  1  downstream valid
- out_ready_i  in  1  downstream ready
- out_res_o  out  RES_W  result
- out_tag_o  out  TAG_W  tag matching out_res_o

Behaviour:
- Stage split:
  - BEFORE: NB=NUM_REGS, NA=0.
  - AFTER: NB=0, NA=NUM_REGS.
  - AROUND: NB=NUM_REGS/2 (floor), NA=NUM_REGS-NB.
- NB stages hold {data, tag} ahead of the datapath. NA stages hold {res, tag} after it.
- Each stage is a full-throughput elastic register:
  - ready_up = ~valid_q | ready_down. Ready is combinational backward; valid/data are registered forward.
  - Load data when valid_up & ready_up. Valid_q becomes valid_up when ready_up, otherwise holds.
  - Data registers do not change without a handshake. Stalled data stays stable.
- Latency is exactly NUM_REGS cycles when out_ready_i stays 1. Throughput is one transaction per cycle.
- NUM_REGS=0: pure combinational path.
  - out_valid_o=in_valid_i, in_ready_o=out_ready_i.
  - out_res_o=dp_res_i, out_tag_o=in_tag_i.
  - clear_i has no effect.
- dp_op_o is driven by the last BEFORE stage data, or by in_data_i if NB=0. It is valid only when that stage's valid is 1 and is don't-care otherwise.
- Reset (rst_ni=0, asynchronous): all stage valids 0 and all data/tag registers 0. Outputs under reset: out_valid_o=0, out_res_o=0, out_tag_o=0. in_ready_o=1 for NUM_REGS>0.
- clear_i=1: all valids cleared next edge; data registers retained. During the clear cycle in_ready_o=1 and the input handshake is discarded. Outputs show out_valid_o=0 from the following cycle.
- Simultaneous pop and push on a full stage: the stage accepts new data in the same cycle (no bubble).
- Backpressure: out_ready_i=0 fills stages back-to-front. in_ready_o drops only when every stage is valid.
- A transaction is never dropped or duplicated. Order is preserved.
- Reset deasserted mid-stream: upstream must re-present data; nothing is lost from the new transaction.

Optional Feature:
- Macro SFM_OP_PIPE_PERF_CNT_EN.
- Defined: adds output stall_cnt_o (32 bits).
  - Increments each cycle out_valid_o & ~out_ready_i, saturating at 0xFFFFFFFF.
  - Zeroed by reset and by clear_i.
- Undefined: port and counter absent; no logic.

Test Plan:
- Reset and REG_CONFIG variants:
  - rst_ni low mid-stream -> out_valid_o=0, out_res_o=0, in_ready_o=1 immediately (asynchronous).
  - NUM_REGS=2, AROUND, datapath = lower 16 bits of sum of in_data_i halves. Feed 0x0003_0005, tag 0x1 -> out_res_o=0x0008, tag 0x1 exactly 2 cycles later.
- Streaming: 100 back-to-back transactions (tags 0..15 cycling) with out_ready_i=1 for each of BEFORE/AFTER/AROUND, NUM_REGS=3 -> one result per cycle, in order, first at cycle 3.
- Backpressure: out_ready_i=0 for 10 cycles, NUM_REGS=4, continuous input.
  - in_ready_o drops after 4 accepts.
  - Held output stable.
  - Release -> all 4 emerge on consecutive cycles, no loss.
- Flush: 3 transactions in flight, assert clear_i for one cycle -> out_valid_o=0 next cycle, none of the 3 ever appear. With SFM_OP_PIPE_PERF_CNT_EN, stall_cnt_o=0.
- NUM_REGS=0: in_ready_o follows out_ready_i combinationally and out_res_o equals dp_res_i in the same cycle. Random out_ready_i with the macro defined -> stall_cnt_o equals the scoreboard count of stalled cycles.
